cache_arbiter: RTL and testbench

- Generates the `sel` control for the two-processor cache mux, so proc1 and proc2 can share one cache port.
- Takes per-processor access requests and grants the cache to one owner at a time.
- Holds `sel` stable for a fixed access latency, then returns a one-cycle acknowledge to the owner.
- Bounded-burst round-robin arbitration prevents either processor from starving the other.

---
 rtl/cache_pkg.sv | 16 +
 rtl/cache_arb_timer.sv | 30 +++
 rtl/cache_arbiter.sv | 118 +++++++++++
 tb/tb_cache_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared encodings for the two-processor cache arbiter and its mux.
// The mux and the benches use these encodings as well.
package cache_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT1 = 2'd1,
      GRANT2 = 2'd2
   } arb_state_t;

   localparam logic SEL_PROC1 = 1'b0;
   localparam logic SEL_PROC2 = 1'b1;

   localparam int CNT_W = 4;

endpackage

// File: rtl/cache_arb_timer.sv
// Hold counter for one granted access.
// last_cycle flags the cycle that carries the owner's Ack.
module cache_arb_timer
   import cache_pkg::*;
#(
   parameter int HOLD_CYCLES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic clr,
   output logic last_cycle
);

   logic [CNT_W-1:0] cnt;

   // Counts only while an access continues; any exit or new grant zeroes it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (start || clr) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign last_cycle = (cnt == CNT_W'(HOLD_CYCLES - 1));

endmodule

// File: rtl/cache_arbiter.sv
// Two-processor cache port arbiter.
// Uses bounded-burst round-robin with a fixed hold time and a one-cycle turnaround.
module cache_arbiter
   import cache_pkg::*;
#(
   parameter int HOLD_CYCLES = 2,
   parameter int MAX_BURST   = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic proc1_Req,
   input  logic proc2_Req,
   output logic proc1_Ack,
   output logic proc2_Ack,
   output logic sel,
   output logic cache_En,
   output logic owner_Busy
);

   localparam logic [CNT_W-1:0] MAX_B = CNT_W'(MAX_BURST);

   arb_state_t       state;
   arb_state_t       next_state;
   logic             last_grant;
   logic [CNT_W-1:0] burst_cnt;
   logic             grant_sel;
   logic             grant_start;
   logic             timer_clr;
   logic             last_cycle;

   // A tie keeps the previous owner only while its current burst is open and below the cap.
   always_comb begin
      grant_sel = SEL_PROC1;
      if (proc1_Req && proc2_Req) begin
         if ((burst_cnt != '0) && (burst_cnt < MAX_B)) begin
            grant_sel = last_grant;
         end else begin
            grant_sel = ~last_grant;
         end
      end else if (proc2_Req) begin
         grant_sel = SEL_PROC2;
      end
   end

   assign grant_start = (state == IDLE) && (proc1_Req || proc2_Req);
   assign timer_clr   = (next_state == IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (grant_start) begin
               next_state = (grant_sel == SEL_PROC2) ? GRANT2 : GRANT1;
            end
         end
         GRANT1: begin
            if (last_cycle || !proc1_Req) begin
               next_state = IDLE;
            end
         end
         GRANT2: begin
            if (last_cycle || !proc2_Req) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      cache_En   = (state != IDLE);
      owner_Busy = (state != IDLE);
      proc1_Ack  = (state == GRANT1) && last_cycle;
      proc2_Ack  = (state == GRANT2) && last_cycle;
   end

   // Grant bookkeeping; sel deliberately keeps its value through IDLE so the mux never toggles needlessly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel        <= SEL_PROC1;
         last_grant <= SEL_PROC2;
         burst_cnt  <= '0;
      end else if (state == IDLE) begin
         if (grant_start) begin
            sel <= grant_sel;
            if (grant_sel == last_grant) begin
               if (burst_cnt < MAX_B) begin
                  burst_cnt <= burst_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
               end
            end else begin
               burst_cnt  <= {{(CNT_W-1){1'b0}}, 1'b1};
               last_grant <= grant_sel;
            end
         end else begin
            burst_cnt <= '0;
         end
      end
   end

   cache_arb_timer #(
      .HOLD_CYCLES(HOLD_CYCLES)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .start     (grant_start),
      .clr       (timer_clr),
      .last_cycle(last_cycle)
   );

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: five differently parameterised instances checked every cycle
// against an access-level model, plus directed literal checks.
module tb_cache_arbiter;
   import cache_pkg::*;

   localparam int N = 5;
   localparam int HOLD_P [N] = '{2, 2, 2, 3, 1};
   localparam int MB_P   [N] = '{4, 2, 1, 4, 4};

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [N-1:0] r1 = '0;
   logic [N-1:0] r2 = '0;
   logic [N-1:0] ack1, ack2, sel, en, busy;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   cache_arbiter #(.HOLD_CYCLES(2), .MAX_BURST(4)) dut_a (
      .clk(clk), .rst(rst), .proc1_Req(r1[0]), .proc2_Req(r2[0]), .proc1_Ack(ack1[0]),
      .proc2_Ack(ack2[0]), .sel(sel[0]), .cache_En(en[0]), .owner_Busy(busy[0]));
   cache_arbiter #(.HOLD_CYCLES(2), .MAX_BURST(2)) dut_b (
      .clk(clk), .rst(rst), .proc1_Req(r1[1]), .proc2_Req(r2[1]), .proc1_Ack(ack1[1]),
      .proc2_Ack(ack2[1]), .sel(sel[1]), .cache_En(en[1]), .owner_Busy(busy[1]));
   cache_arbiter #(.HOLD_CYCLES(2), .MAX_BURST(1)) dut_c (
      .clk(clk), .rst(rst), .proc1_Req(r1[2]), .proc2_Req(r2[2]), .proc1_Ack(ack1[2]),
      .proc2_Ack(ack2[2]), .sel(sel[2]), .cache_En(en[2]), .owner_Busy(busy[2]));
   cache_arbiter #(.HOLD_CYCLES(3), .MAX_BURST(4)) dut_d (
      .clk(clk), .rst(rst), .proc1_Req(r1[3]), .proc2_Req(r2[3]), .proc1_Ack(ack1[3]),
      .proc2_Ack(ack2[3]), .sel(sel[3]), .cache_En(en[3]), .owner_Busy(busy[3]));
   cache_arbiter #(.HOLD_CYCLES(1), .MAX_BURST(4)) dut_e (
      .clk(clk), .rst(rst), .proc1_Req(r1[4]), .proc2_Req(r2[4]), .proc1_Ack(ack1[4]),
      .proc2_Ack(ack2[4]), .sel(sel[4]), .cache_En(en[4]), .owner_Busy(busy[4]));

   // Access-level model: cycles remaining in the current access, its owner (0/1),
   // the processor that owns the running streak, and the streak length.
   int rem    [N];
   int own    [N];
   int last   [N];
   int streak [N];
   int winner;

   always @(posedge clk or posedge rst) begin
      for (int i = 0; i < N; i++) begin
         if (rst) begin
            rem[i]    = 0;
            own[i]    = 0;
            last[i]   = 1;
            streak[i] = 0;
         end else if (rem[i] > 0) begin
            if (rem[i] == 1 || !((own[i] == 0) ? r1[i] : r2[i])) rem[i] = 0;
            else rem[i] = rem[i] - 1;
         end else if (r1[i] || r2[i]) begin
            if (r1[i] && r2[i])
               winner = (streak[i] > 0 && streak[i] < MB_P[i]) ? last[i] : 1 - last[i];
            else
               winner = r2[i] ? 1 : 0;
            if (winner == last[i]) begin
               if (streak[i] < MB_P[i]) streak[i] = streak[i] + 1;
            end else begin
               streak[i] = 1;
               last[i]   = winner;
            end
            own[i] = winner;
            rem[i] = HOLD_P[i];
         end else begin
            streak[i] = 0;
         end
      end
   end

   task automatic checkOutput(input string name, input int idx, input logic actual,
                              input logic expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s[%0d] at %0t: got %b, expected %b", name, idx, $time,
                  actual, expected);
      end
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < N; i++) begin
         checkOutput("model_sel",  i, sel[i],  own[i] == 1);
         checkOutput("model_en",   i, en[i],   rem[i] > 0);
         checkOutput("model_busy", i, busy[i], rem[i] > 0);
         checkOutput("model_ack1", i, ack1[i], rem[i] == 1 && own[i] == 0);
         checkOutput("model_ack2", i, ack2[i], rem[i] == 1 && own[i] == 1);
      end
   end

   task automatic nextCycle();
      @(negedge clk);
      #1;
   endtask

   task automatic applyStimulus(input int idx, input logic p1, input logic p2);
      r1[idx] = p1;
      r2[idx] = p2;
   endtask

   task automatic pulseReset();
      rst = 1'b1;
      nextCycle();
      rst = 1'b0;
   endtask

   int exp_a [5] = '{1, 1, 1, 1, 2};
   int exp_b [5] = '{1, 1, 2, 2, 1};
   int exp_c [5] = '{1, 2, 1, 2, 1};

   initial begin
      nextCycle();
      nextCycle();
      checkOutput("reset_sel",  0, sel[0],  SEL_PROC1);
      checkOutput("reset_en",   0, en[0],   1'b0);
      checkOutput("reset_ack1", 0, ack1[0], 1'b0);
      checkOutput("reset_ack2", 0, ack2[0], 1'b0);
      checkOutput("reset_busy", 0, busy[0], 1'b0);
      rst = 1'b0;
      nextCycle();

      // Single proc1 access, HOLD=2
      applyStimulus(0, 1'b1, 1'b0);
      nextCycle();
      checkOutput("single_en_c1",   0, en[0],   1'b1);
      checkOutput("single_sel_c1",  0, sel[0],  SEL_PROC1);
      checkOutput("single_ack_c1",  0, ack1[0], 1'b0);
      nextCycle();
      checkOutput("single_en_c2",   0, en[0],   1'b1);
      checkOutput("single_ack_c2",  0, ack1[0], 1'b1);
      applyStimulus(0, 1'b0, 1'b0);
      nextCycle();
      checkOutput("single_en_c3",   0, en[0],   1'b0);
      checkOutput("single_busy_c3", 0, busy[0], 1'b0);
      checkOutput("single_ack_c3",  0, ack1[0], 1'b0);
      checkOutput("single_sel_c3",  0, sel[0],  SEL_PROC1);

      // Both requesting from reset with MAX_BURST of 4, 2 and 1
      pulseReset();
      for (int i = 0; i < 3; i++) applyStimulus(i, 1'b1, 1'b1);
      for (int j = 0; j < 5; j++) begin
         nextCycle();
         nextCycle();
         checkOutput("burst4_ack1", j, ack1[0], exp_a[j] == 1);
         checkOutput("burst4_ack2", j, ack2[0], exp_a[j] == 2);
         checkOutput("burst4_sel",  j, sel[0],  exp_a[j] == 2);
         checkOutput("burst2_ack1", j, ack1[1], exp_b[j] == 1);
         checkOutput("burst2_ack2", j, ack2[1], exp_b[j] == 2);
         checkOutput("burst2_sel",  j, sel[1],  exp_b[j] == 2);
         checkOutput("alt_ack1",    j, ack1[2], exp_c[j] == 1);
         checkOutput("alt_ack2",    j, ack2[2], exp_c[j] == 2);
         checkOutput("alt_sel",     j, sel[2],  exp_c[j] == 2);
         nextCycle();
         checkOutput("burst2_turnaround", j, en[1], 1'b0);
         checkOutput("alt_turnaround",    j, en[2], 1'b0);
      end
      for (int i = 0; i < 3; i++) applyStimulus(i, 1'b0, 1'b0);

      // Abort: proc2 drops Req in its first grant cycle, HOLD=3
      applyStimulus(3, 1'b0, 1'b1);
      nextCycle();
      checkOutput("abort_sel_grant", 3, sel[3],  SEL_PROC2);
      checkOutput("abort_en_grant",  3, en[3],   1'b1);
      checkOutput("abort_ack_grant", 3, ack2[3], 1'b0);
      applyStimulus(3, 1'b0, 1'b0);
      nextCycle();
      checkOutput("abort_en_idle",  3, en[3],   1'b0);
      checkOutput("abort_ack_idle", 3, ack2[3], 1'b0);
      checkOutput("abort_sel_idle", 3, sel[3],  SEL_PROC2);
      nextCycle();
      checkOutput("abort_ack_late", 3, ack2[3], 1'b0);
      checkOutput("abort_sel_late", 3, sel[3],  SEL_PROC2);

      // Reset in the middle of a proc2 grant
      applyStimulus(0, 1'b0, 1'b1);
      nextCycle();
      checkOutput("rstmid_sel_pre", 0, sel[0], SEL_PROC2);
      checkOutput("rstmid_en_pre",  0, en[0],  1'b1);
      rst = 1'b1;
      applyStimulus(0, 1'b1, 1'b1);
      #1;
      checkOutput("rstmid_sel_now",  0, sel[0],  SEL_PROC1);
      checkOutput("rstmid_en_now",   0, en[0],   1'b0);
      checkOutput("rstmid_ack2_now", 0, ack2[0], 1'b0);
      checkOutput("rstmid_busy_now", 0, busy[0], 1'b0);
      nextCycle();
      rst = 1'b0;
      nextCycle();
      checkOutput("rstmid_first_sel", 0, sel[0], SEL_PROC1);
      checkOutput("rstmid_first_en",  0, en[0],  1'b1);
      nextCycle();
      checkOutput("rstmid_first_ack", 0, ack1[0], 1'b1);
      applyStimulus(0, 1'b0, 1'b0);

      // HOLD=1 with proc1 requesting continuously
      applyStimulus(4, 1'b1, 1'b0);
      for (int j = 0; j < 6; j++) begin
         nextCycle();
         checkOutput("hold1_busy", j, busy[4], (j % 2) == 0);
         checkOutput("hold1_ack1", j, ack1[4], (j % 2) == 0);
      end
      applyStimulus(4, 1'b0, 1'b0);

      nextCycle();
      nextCycle();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
